// File: rtl/stat_display.sv
// Shows one of four 16-bit instruction counters in decimal on an 8-digit 7-segment display.
// Optional leading-zero blanking of digits 4..1 is enabled by defining STAT_DISPLAY_LZB_EN.
module stat_display #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  sel,
  input  logic [15:0] J,
  input  logic [15:0] B,
  input  logic [15:0] Br,
  input  logic [15:0] All,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  localparam logic [19:0] DivMax = 20'(SCAN_DIV - 1);

  state_e      state_q, state_d;
  logic [15:0] bin_q, bin_d;
  logic [1:0]  sel_snap_q, sel_snap_d;
  logic [19:0] bcd_sh_q, bcd_sh_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] bcd_res_q, bcd_res_d;
  logic [1:0]  sel_lat_q, sel_lat_d;
  logic        busy_q, busy_d;
  logic [19:0] adj;

  logic [19:0] div_q;
  logic [2:0]  idx_q;
  logic [7:0]  an_d, seg_d;
  logic [4:1]  lead_zero;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  // Double-dabble correction applied before each shift.
  always_comb begin
    adj = bcd_sh_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_sh_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_sh_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    sel_snap_d = sel_snap_q;
    bcd_sh_d   = bcd_sh_q;
    cnt_d      = cnt_q;
    bcd_res_d  = bcd_res_q;
    sel_lat_d  = sel_lat_q;
    busy_d     = busy_q;
    case (state_q)
      StIdle: begin
        case (sel)
          2'd0:    bin_d = J;
          2'd1:    bin_d = B;
          2'd2:    bin_d = Br;
          default: bin_d = All;
        endcase
        sel_snap_d = sel;
        busy_d     = 1'b1;
        state_d    = StLoad;
      end
      StLoad: begin
        bcd_sh_d = '0;
        cnt_d    = '0;
        state_d  = StShift;
      end
      StShift: begin
        {bcd_sh_d, bin_d} = {adj[18:0], bin_q, 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = StDone;
      end
      StDone: begin
        bcd_res_d = bcd_sh_q;
        sel_lat_d = sel_snap_q;
        busy_d    = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      bin_q      <= '0;
      sel_snap_q <= '0;
      bcd_sh_q   <= '0;
      cnt_q      <= '0;
      bcd_res_q  <= '0;
      sel_lat_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      sel_snap_q <= sel_snap_d;
      bcd_sh_q   <= bcd_sh_d;
      cnt_q      <= cnt_d;
      bcd_res_q  <= bcd_res_d;
      sel_lat_q  <= sel_lat_d;
      busy_q     <= busy_d;
    end
  end

  assign busy = busy_q;

  // lead_zero[k]: digit k and every digit above it are zero.
  always_comb begin
    lead_zero[4] = (bcd_res_q[19:16] == 4'd0);
    lead_zero[3] = lead_zero[4] && (bcd_res_q[15:12] == 4'd0);
    lead_zero[2] = lead_zero[3] && (bcd_res_q[11:8] == 4'd0);
    lead_zero[1] = lead_zero[2] && (bcd_res_q[7:4] == 4'd0);
  end

  always_comb begin
    an_d = ~(8'b1 << idx_q);
    case (idx_q)
      3'd0:    seg_d = seg_code(bcd_res_q[3:0]);
      3'd1:    seg_d = seg_code(bcd_res_q[7:4]);
      3'd2:    seg_d = seg_code(bcd_res_q[11:8]);
      3'd3:    seg_d = seg_code(bcd_res_q[15:12]);
      3'd4:    seg_d = seg_code(bcd_res_q[19:16]);
      3'd7:    seg_d = seg_code({2'b00, sel_lat_q});
      default: seg_d = 8'hFF;
    endcase
`ifdef STAT_DISPLAY_LZB_EN
    if (idx_q >= 3'd1 && idx_q <= 3'd4 && lead_zero[idx_q]) seg_d = 8'hFF;
`endif
  end

  // an/seg latch the content of the slot being left as the index advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
      an    <= 8'hFF;
      seg   <= 8'hFF;
    end else if (div_q == DivMax) begin
      div_q <= '0;
      idx_q <= idx_q + 3'd1;
      an    <= an_d;
      seg   <= seg_d;
    end else begin
      div_q <= div_q + 20'd1;
    end
  end

endmodule

// File: tb/tb_stat_display.sv
// Randomized self-checking bench for stat_display with a decimal-arithmetic reference model.
module tb_stat_display;

  localparam int unsigned ScanDiv = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  sel = 2'd0;
  logic [15:0] J = '0, B = '0, Br = '0, All = '0;
  logic [7:0]  an, seg;
  logic        busy;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  stat_display #(.SCAN_DIV(ScanDiv)) dut (
    .clk  (clk),
    .rst  (rst),
    .sel  (sel),
    .J    (J),
    .B    (B),
    .Br   (Br),
    .All  (All),
    .an   (an),
    .seg  (seg),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] code7(input int unsigned d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Expected segments for display slot idx when showing val with selector s.
  function automatic logic [7:0] exp_seg(input int unsigned val, input int unsigned s,
                                         input int idx);
    int unsigned p = 1;
    if (idx == 7) return code7(s);
    if (idx == 5 || idx == 6) return 8'hFF;
    for (int i = 0; i < idx; i++) p = p * 10;
`ifdef STAT_DISPLAY_LZB_EN
    if (idx > 0 && val < p) return 8'hFF;
`endif
    return code7((val / p) % 10);
  endfunction

  function automatic int unsigned sel_val(input int unsigned s);
    case (s)
      0: return J;
      1: return B;
      2: return Br;
      default: return All;
    endcase
  endfunction

  task automatic wait_fall();
    logic p;
    bit found = 0;
    @(negedge clk);
    p = busy;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (p && !busy) found = 1;
      p = busy;
    end
    check("busy_fall_seen", 32'(found), 32'd1);
  endtask

  task automatic wait_rise();
    logic p;
    bit found = 0;
    @(negedge clk);
    p = busy;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (!p && busy) found = 1;
      p = busy;
    end
    check("busy_rise_seen", 32'(found), 32'd1);
  endtask

  // Observe the display and busy for a number of cycles, checking every digit change.
  task automatic watch(input int cycles, input int unsigned val, input int unsigned s);
    logic [7:0] prev_an;
    logic       prev_busy;
    int         since = 0, fall_gap = 0, idx;
    bit         have_edge = 0, have_fall = 0;
    @(negedge clk);
    prev_an = an;
    prev_busy = busy;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      since++;
      fall_gap++;
      if (an != prev_an) begin
        idx = 0;
        for (int k = 0; k < 8; k++) if (!an[k]) idx = k;
        check("an_onehot", 32'($countones(~an)), 32'd1);
        if (prev_an != 8'hFF) check("an_rotate", 32'(an), 32'({prev_an[6:0], prev_an[7]}));
        if (have_edge) check("scan_period", 32'(since), 32'(ScanDiv));
        check($sformatf("seg_digit%0d", idx), 32'(seg), 32'(exp_seg(val, s, idx)));
        have_edge = 1;
        since = 0;
        prev_an = an;
      end
      if (prev_busy && !busy) begin
        if (have_fall) check("busy_period", 32'(fall_gap), 32'd19);
        have_fall = 1;
        fall_gap = 0;
      end
      if (!prev_busy && !busy) check("busy_low_one_cycle", 32'(busy), 32'd1);
      prev_busy = busy;
    end
    check("scan_active", 32'(have_edge), 32'd1);
  endtask

  task automatic settle_and_watch();
    wait_fall();
    wait_fall();
    watch(40, sel_val(sel), sel);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_an", 32'(an), 32'hFF);
    check("reset_seg", 32'(seg), 32'hFF);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    sel = 2'd3; All = 16'd12345;
    settle_and_watch();
    sel = 2'd0; J = 16'd65535;
    settle_and_watch();
    J = 16'd0;
    settle_and_watch();
    sel = 2'd3; All = 16'd507;
    settle_and_watch();
    All = 16'd0;
    settle_and_watch();

    // Inputs changed mid-SHIFT must not affect the conversion in flight.
    sel = 2'd2; Br = 16'd7; B = 16'd58369;
    wait_fall();
    wait_fall();
    wait_rise();
    repeat (3) @(negedge clk);
    sel = 2'd1; Br = 16'd9;
    wait_fall();
    watch(17, 7, 2);
    wait_fall();
    watch(17, 58369, 1);

    for (int it = 0; it < 6; it++) begin
      J = 16'($urandom); B = 16'($urandom); Br = 16'($urandom); All = 16'($urandom);
      if (it == 2) Br = 16'd65535;
      if (it == 3) All = 16'($urandom_range(0, 99));
      sel = 2'($urandom_range(0, 3));
      settle_and_watch();
    end

    // Asynchronous reset in the middle of SHIFT.
    wait_rise();
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset_an", 32'(an), 32'hFF);
    check("midreset_seg", 32'(seg), 32'hFF);
    check("midreset_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rel_busy_edge1", 32'(busy), 32'd1);
    repeat (2) @(posedge clk); #1;
    check("rel_an_edge3", 32'(an), 32'hFF);
    @(posedge clk); #1;
    check("rel_an_edge4", 32'(an), 32'hFE);
    repeat (14) @(posedge clk); #1;
    check("rel_busy_edge18", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("rel_busy_edge19", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("rel_busy_edge20", 32'(busy), 32'd1);
    watch(40, sel_val(sel), sel);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
